// File: rtl/wrf_pkg.sv
// Shared WR fabric definitions: word-type codes and the buffered entry layout.
package wrf_pkg;

   localparam logic [1:0] WRF_DATA   = 2'd0;
   localparam logic [1:0] WRF_OOB    = 2'd1;
   localparam logic [1:0] WRF_STATUS = 2'd2;
   localparam logic [1:0] WRF_USER   = 2'd3;

   // One buffered fabric word plus its framing flags (22 bits).
   typedef struct packed {
      logic        sof;
      logic        eof;
      logic        error;
      logic        bytesel;
      logic [1:0]  adr;
      logic [15:0] dat;
   } wrf_entry_t;

endpackage

// File: rtl/wrf_sink_fifo.sv
// First-word-fall-through FIFO of fabric entries with an occupancy count.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module wrf_sink_fifo
   import wrf_pkg::*;
#(
   parameter int unsigned g_fifo_log2 = 4
) (
   input  logic                 clk_sys_i,
   input  logic                 rst_n_i,
   input  logic                 push_i,
   input  wrf_entry_t           wr_data_i,
   input  logic                 pop_i,
   output wrf_entry_t           rd_data_o,
   output logic                 empty_o,
   output logic [g_fifo_log2:0] count_o
);

   localparam int unsigned Depth = 2 ** g_fifo_log2;

   logic [g_fifo_log2:0] wr_ptr_q, wr_ptr_d;
   logic [g_fifo_log2:0] rd_ptr_q, rd_ptr_d;
   wrf_entry_t           mem_q [Depth];
   logic                 full;
   logic                 do_push;
   logic                 do_pop;

   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[g_fifo_log2] != rd_ptr_q[g_fifo_log2]) &&
                    (wr_ptr_q[g_fifo_log2-1:0] == rd_ptr_q[g_fifo_log2-1:0]);

   // A push into a full FIFO is still taken when the head leaves in the same cycle.
   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full | do_pop);

   assign count_o   = wr_ptr_q - rd_ptr_q;
   assign rd_data_o = mem_q[rd_ptr_q[g_fifo_log2-1:0]];

   // Pointer advance
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
   end

   // Pointer registers
   always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage array; contents are don't-care until written
   always_ff @(posedge clk_sys_i) begin
      if (do_push) mem_q[wr_ptr_q[g_fifo_log2-1:0]] <= wr_data_i;
   end

endmodule

// File: rtl/wrf_fabric_sink_buffer.sv
// Receive end of the pipelined WB WR fabric. Accepts frame words as a WB slave,
// tags SOF/EOF/error through a one-word stage and replays them as valid/dreq.
module wrf_fabric_sink_buffer
   import wrf_pkg::*;
#(
   parameter int unsigned g_fifo_log2 = 4,
   parameter int unsigned g_err_bit   = 1
) (
   input  logic        clk_sys_i,
   input  logic        rst_n_i,
   input  logic        snk_cyc_i,
   input  logic        snk_stb_i,
   input  logic        snk_we_i,
   input  logic [1:0]  snk_adr_i,
   input  logic [1:0]  snk_sel_i,
   input  logic [15:0] snk_dat_i,
   output logic        snk_ack_o,
   output logic        snk_stall_o,
   output logic        snk_err_o,
   output logic [15:0] src_dat_o,
   output logic [1:0]  src_adr_o,
   output logic        src_bytesel_o,
   output logic        src_sof_o,
   output logic        src_eof_o,
   output logic        src_error_o,
   output logic        src_valid_o,
   input  logic        src_dreq_i,
   output logic [15:0] frames_o
);

   localparam int unsigned Depth = 2 ** g_fifo_log2;
   // Stall threshold leaves room for one word in flight plus the stage flush.
   localparam logic [g_fifo_log2:0] StallLevel = (g_fifo_log2 + 1)'(Depth - 2);

   logic                 cyc_q;
   logic                 stall_q, stall_d;
   logic                 ack_q, ack_d;
   logic                 rd_err_q, rd_err_d;
   logic                 frame_err_q, frame_err_d;
   logic                 sof_pend_q, sof_pend_d;
   logic                 stage_valid_q, stage_valid_d;
   wrf_entry_t           stage_q, stage_d;
   logic [15:0]          frames_q, frames_d;

   logic                 accept;
   logic                 accept_wr;
   logic                 cyc_rise;
   logic                 cyc_fall;
   logic                 push;
   wrf_entry_t           push_entry;
   logic                 pop;
   wrf_entry_t           head;
   logic                 fifo_empty;
   logic [g_fifo_log2:0] fifo_count;

   assign accept    = snk_cyc_i & snk_stb_i & ~stall_q;
   assign accept_wr = accept & snk_we_i;
   assign cyc_rise  = snk_cyc_i & ~cyc_q;
   assign cyc_fall  = ~snk_cyc_i & cyc_q;
   assign pop       = src_dreq_i & ~fifo_empty;

   // WB handshake, stage and frame-flag next state
   always_comb begin
      ack_d         = accept_wr;
      rd_err_d      = accept & ~snk_we_i;
      stall_d       = (fifo_count >= StallLevel);
      frame_err_d   = frame_err_q;
      sof_pend_d    = sof_pend_q;
      stage_valid_d = stage_valid_q;
      stage_d       = stage_q;

      if (cyc_rise) frame_err_d = 1'b0;
      if (accept_wr && (snk_adr_i == WRF_STATUS) && snk_dat_i[g_err_bit]) frame_err_d = 1'b1;

      // SOF is armed whenever no frame is open and consumed by the first write.
      if (!snk_cyc_i)     sof_pend_d = 1'b1;
      else if (accept_wr) sof_pend_d = 1'b0;

      if (accept_wr) begin
         stage_valid_d   = 1'b1;
         stage_d.sof     = sof_pend_q;
         stage_d.eof     = 1'b0;
         stage_d.error   = 1'b0;
         stage_d.bytesel = (snk_sel_i == 2'b10);
         stage_d.adr     = snk_adr_i;
         stage_d.dat     = snk_dat_i;
      end else if (cyc_fall) begin
         stage_valid_d = 1'b0;
      end
   end

   // Stage drain into the FIFO: a new write displaces the staged word, cyc fall flushes it as EOF.
   // accept_wr needs cyc high and cyc_fall needs cyc low, so at most one push per cycle.
   always_comb begin
      push       = 1'b0;
      push_entry = stage_q;
      if (accept_wr && stage_valid_q) begin
         push             = 1'b1;
         push_entry.eof   = 1'b0;
         push_entry.error = 1'b0;
      end else if (cyc_fall && stage_valid_q) begin
         push             = 1'b1;
         push_entry.eof   = 1'b1;
         push_entry.error = frame_err_q;
      end
   end

   // Frame counter advances when an EOF entry leaves the buffer
   always_comb begin
      frames_d = frames_q;
      if (pop && head.eof) frames_d = frames_q + 16'd1;
   end

   // State registers
   always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cyc_q         <= 1'b0;
         stall_q       <= 1'b0;
         ack_q         <= 1'b0;
         rd_err_q      <= 1'b0;
         frame_err_q   <= 1'b0;
         sof_pend_q    <= 1'b1;
         stage_valid_q <= 1'b0;
         stage_q       <= '0;
         frames_q      <= '0;
      end else begin
         cyc_q         <= snk_cyc_i;
         stall_q       <= stall_d;
         ack_q         <= ack_d;
         rd_err_q      <= rd_err_d;
         frame_err_q   <= frame_err_d;
         sof_pend_q    <= sof_pend_d;
         stage_valid_q <= stage_valid_d;
         stage_q       <= stage_d;
         frames_q      <= frames_d;
      end
   end

   wrf_sink_fifo #(
      .g_fifo_log2 (g_fifo_log2)
   ) u_fifo (
      .clk_sys_i (clk_sys_i),
      .rst_n_i   (rst_n_i),
      .push_i    (push),
      .wr_data_i (push_entry),
      .pop_i     (pop),
      .rd_data_o (head),
      .empty_o   (fifo_empty),
      .count_o   (fifo_count)
   );

   // Source outputs are forced to zero while the buffer is empty
   always_comb begin
      src_dat_o     = '0;
      src_adr_o     = '0;
      src_bytesel_o = 1'b0;
      src_sof_o     = 1'b0;
      src_eof_o     = 1'b0;
      src_error_o   = 1'b0;
      if (!fifo_empty) begin
         src_dat_o     = head.dat;
         src_adr_o     = head.adr;
         src_bytesel_o = head.bytesel;
         src_sof_o     = head.sof;
         src_eof_o     = head.eof;
         src_error_o   = head.error;
      end
   end

   assign src_valid_o = ~fifo_empty;
   assign snk_ack_o   = ack_q;
   assign snk_stall_o = stall_q;
   assign snk_err_o   = rd_err_q;
   assign frames_o    = frames_q;

endmodule
